// File: rtl/mp_addsub_chunked.sv
`default_nettype none
// ============================================================================
// mp_addsub_chunked : multi-cycle WIDTH-bit add/sub, CHUNK bits per cycle
// Revision 1.0
// ============================================================================
module mp_addsub_chunked #(
   parameter int WIDTH = 514,
   parameter int CHUNK = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   output logic [WIDTH:0]   result,
   output logic             borrow,
   output logic             busy,
   output logic             done
);

   localparam int NCHUNK = (WIDTH + CHUNK) / CHUNK;
   localparam int PADW   = NCHUNK * CHUNK;
   localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t          r_state;
   state_t          w_state_next;
   logic [PADW-1:0] r_a;
   logic [PADW-1:0] r_b;
   logic [PADW-1:0] r_acc;
   logic [PADW-1:0] w_acc_next;
   logic [CW-1:0]   r_cnt;
   logic            r_carry;
   logic [1:0]      r_op;
   logic            w_accept;
   logic            w_last;
   logic [CHUNK-1:0] w_b_slice;
   logic [CHUNK:0]  w_sum;

   assign w_accept  = start && (r_state != S_RUN);
   assign w_last    = (r_cnt == CW'(NCHUNK - 1));
   // Operands shift down one slice per cycle, so the active slice is always at bit 0
   assign w_b_slice = r_op[0] ? ~r_b[CHUNK-1:0] : r_b[CHUNK-1:0];
   assign w_sum     = {1'b0, r_a[CHUNK-1:0]} + {1'b0, w_b_slice} + {{CHUNK{1'b0}}, r_carry};

   // New slice enters at the top; after NCHUNK steps slice k sits at position k
   generate
      if (NCHUNK > 1) begin : g_multi
         assign w_acc_next = {w_sum[CHUNK-1:0], r_acc[PADW-1:CHUNK]};
      end else begin : g_single
         assign w_acc_next = w_sum[CHUNK-1:0];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      busy         = 1'b0;
      done         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (start) w_state_next = S_RUN;
         end
         S_RUN: begin
            busy = 1'b1;
            if (w_last) w_state_next = S_DONE;
         end
         S_DONE: begin
            done         = 1'b1;
            w_state_next = start ? S_RUN : S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_a     <= '0;
         r_b     <= '0;
         r_acc   <= '0;
         r_cnt   <= '0;
         r_carry <= 1'b0;
         r_op    <= 2'b00;
         result  <= '0;
         borrow  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= PADW'(in_a);
         r_b     <= PADW'(in_b);
         r_op    <= op;
         r_carry <= op[0];
         r_cnt   <= '0;
      end else if (r_state == S_RUN) begin
         r_a     <= r_a >> CHUNK;
         r_b     <= r_b >> CHUNK;
         r_acc   <= w_acc_next;
         r_carry <= w_sum[CHUNK];
         r_cnt   <= r_cnt + 1'b1;
         if (w_last) begin
            result <= r_op[1] ? {1'b0, w_acc_next[WIDTH:1]} : w_acc_next[WIDTH:0];
            borrow <= r_op[0] & w_acc_next[WIDTH];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mp_addsub_chunked.sv
`default_nettype none
// ============================================================================
// tb_mp_addsub_chunked : randomized self-checking bench for mp_addsub_chunked
// Revision 1.0
// ============================================================================
module tb_mp_addsub_chunked;

   localparam int W = 514;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [1:0]   op;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic [W:0]   result;
   logic         borrow;
   logic         busy;
   logic         done;

   logic         sw_start;
   logic [1:0]   sw_op;
   logic [W-1:0] sw_a;
   logic [W-1:0] sw_b;
   logic [W:0]   sw_result [4];
   logic         sw_borrow [4];
   logic         sw_busy   [4];
   logic         sw_done   [4];

   int n_tests = 0;
   int n_fail  = 0;
   logic stab_err;

   always #5 clk = ~clk;

   mp_addsub_chunked #(.WIDTH(W), .CHUNK(128)) u_dut (
      .clk(clk), .reset(reset), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
      .result(result), .borrow(borrow), .busy(busy), .done(done)
   );

   generate
      for (genvar g = 0; g < 4; g++) begin : g_sweep
         localparam int CK = (g == 0) ? 1 : (g == 1) ? 7 : (g == 2) ? 172 : 515;
         mp_addsub_chunked #(.WIDTH(W), .CHUNK(CK)) u_sw (
            .clk(clk), .reset(reset), .start(sw_start), .op(sw_op), .in_a(sw_a), .in_b(sw_b),
            .result(sw_result[g]), .borrow(sw_borrow[g]), .busy(sw_busy[g]), .done(sw_done[g])
         );
      end
   endgenerate

   // Reference: plain integer arithmetic on (W+1)-bit values
   function automatic void model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                                 output logic [W:0] r, output logic bw);
      logic [W:0] s;
      if (o[0]) s = {1'b0, a} - {1'b0, b};
      else      s = {1'b0, a} + {1'b0, b};
      r  = o[1] ? (s >> 1) : s;
      bw = o[0] && (a < b);
   endfunction

   function automatic logic [W-1:0] rnd_opnd();
      logic [W-1:0] v;
      v = '0;
      for (int i = 0; i < W; i += 32) v = (v << 32) | W'($urandom);
      case ($urandom_range(0, 5))
         0:       v = W'($urandom_range(0, 15));
         1:       v = '1;
         default: ;
      endcase
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                         output int lat, output int busy_cnt, output logic [W:0] r, output logic bw);
      logic [W:0] held;
      op = o; in_a = a; in_b = b; start = 1'b1;
      tick();
      start = 1'b0; in_a = ~a; in_b = ~b;
      lat = 1; busy_cnt = 0; stab_err = 1'b0;
      held = result;
      while (!done && lat < 60) begin
         if (busy) busy_cnt++;
         if (busy && result !== held) stab_err = 1'b1;
         tick();
         lat++;
      end
      r = result; bw = borrow;
   endtask

   task automatic test_reset();
      int lat, bc; logic [W:0] r; logic bw; logic [W:0] er; logic ebw; logic seen;
      reset = 1'b1; start = 1'b0; op = 2'b00; in_a = '0; in_b = '0;
      sw_start = 1'b0; sw_op = 2'b00; sw_a = '0; sw_b = '0;
      repeat (3) tick();
      reset = 1'b0;
      tick();
      n_tests++; if (result !== '0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
      n_tests++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL reset_borrow: got %b expected 0", borrow); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
      run_op(2'b00, W'(100), W'(23), lat, bc, r, bw);
      n_tests++; if (r !== (W+1)'(123)) begin n_fail++; $display("FAIL pre_reset_add: got %h expected 7b", r); end
      tick();
      op = 2'b00; in_a = W'(77); in_b = W'(11); start = 1'b1;
      tick();
      start = 1'b0;
      tick(); tick();
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrun_busy: got %b expected 1", busy); end
      reset = 1'b1;
      #1;
      n_tests++; if (result !== '0) begin n_fail++; $display("FAIL abort_result: got %h expected 0", result); end
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort_busy: got %b expected 0", busy); end
      tick();
      reset = 1'b0;
      seen = 1'b0;
      repeat (10) begin tick(); if (done) seen = 1'b1; end
      n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL abort_no_done: got %b expected 0", seen); end
      n_tests++; if (borrow !== 1'b0) begin n_fail++; $display("FAIL abort_borrow: got %b expected 0", borrow); end
      reset = 1'b1; start = 1'b1;
      tick(); tick();
      reset = 1'b0; start = 1'b0;
      tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_wins_busy: got %b expected 0", busy); end
      run_op(2'b01, W'(5), W'(9), lat, bc, r, bw);
      model(2'b01, W'(5), W'(9), er, ebw);
      n_tests++; if (r !== er) begin n_fail++; $display("FAIL post_reset_sub: got %h expected %h", r, er); end
      n_tests++; if (bw !== ebw) begin n_fail++; $display("FAIL post_reset_borrow: got %b expected %b", bw, ebw); end
      n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 6", lat); end
   endtask

   task automatic test_add_carry();
      int lat, bc; logic [W:0] r; logic bw; logic [W:0] er;
      er = '0; er[W] = 1'b1;
      run_op(2'b00, {W{1'b1}}, W'(1), lat, bc, r, bw);
      n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL carry_latency: got %0d expected 6", lat); end
      n_tests++; if (bc !== 5) begin n_fail++; $display("FAIL carry_busy_cycles: got %0d expected 5", bc); end
      n_tests++; if (r !== er) begin n_fail++; $display("FAIL carry_result: got %h expected %h", r, er); end
      n_tests++; if (bw !== 1'b0) begin n_fail++; $display("FAIL carry_borrow: got %b expected 0", bw); end
      tick();
      n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b expected 0", done); end
   endtask

   task automatic test_sub();
      int lat, bc; logic [W:0] r; logic bw; logic [W:0] er;
      er = '1; er[0] = 1'b0;
      run_op(2'b01, W'(5), W'(7), lat, bc, r, bw);
      n_tests++; if (r !== er) begin n_fail++; $display("FAIL sub_neg_result: got %h expected %h", r, er); end
      n_tests++; if (bw !== 1'b1) begin n_fail++; $display("FAIL sub_neg_borrow: got %b expected 1", bw); end
      tick();
      run_op(2'b01, W'(7), W'(5), lat, bc, r, bw);
      n_tests++; if (r !== (W+1)'(2)) begin n_fail++; $display("FAIL sub_pos_result: got %h expected 2", r); end
      n_tests++; if (bw !== 1'b0) begin n_fail++; $display("FAIL sub_pos_borrow: got %b expected 0", bw); end
      tick();
   endtask

   task automatic test_shift();
      int lat, bc; logic [W:0] r; logic bw; logic [W:0] er;
      er = {1'b0, {W{1'b1}}};
      run_op(2'b10, {W{1'b1}}, {W{1'b1}}, lat, bc, r, bw);
      n_tests++; if (r !== er) begin n_fail++; $display("FAIL shift_max_result: got %h expected %h", r, er); end
      tick();
      run_op(2'b10, W'(3), W'(0), lat, bc, r, bw);
      n_tests++; if (r !== (W+1)'(1)) begin n_fail++; $display("FAIL shift_floor_result: got %h expected 1", r); end
      tick();
   endtask

   task automatic test_ignore_start();
      logic [W-1:0] a, b; logic [W:0] er; logic ebw; int lat;
      a = rnd_opnd(); b = rnd_opnd();
      model(2'b00, a, b, er, ebw);
      op = 2'b00; in_a = a; in_b = b; start = 1'b1;
      tick();
      start = 1'b0; lat = 1;
      tick(); tick(); lat += 2;
      op = 2'b11; in_a = rnd_opnd(); in_b = rnd_opnd(); start = 1'b1;
      tick(); lat++;
      start = 1'b0;
      while (!done && lat < 60) begin tick(); lat++; end
      n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL ignore_latency: got %0d expected 6", lat); end
      n_tests++; if (result !== er) begin n_fail++; $display("FAIL ignore_result: got %h expected %h", result, er); end
      n_tests++; if (borrow !== ebw) begin n_fail++; $display("FAIL ignore_borrow: got %b expected %b", borrow, ebw); end
      tick();
      n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignore_idle: got %b expected 0", busy); end
   endtask

   task automatic test_back_to_back();
      logic [W-1:0] a1, b1, a2, b2; logic [W:0] er1, er2; logic eb1, eb2; int lat;
      a1 = rnd_opnd(); b1 = rnd_opnd(); a2 = rnd_opnd(); b2 = rnd_opnd();
      model(2'b01, a1, b1, er1, eb1);
      model(2'b11, a2, b2, er2, eb2);
      op = 2'b01; in_a = a1; in_b = b1; start = 1'b1;
      tick();
      start = 1'b0; lat = 1;
      while (!done && lat < 60) begin tick(); lat++; end
      n_tests++; if (result !== er1) begin n_fail++; $display("FAIL b2b_first_result: got %h expected %h", result, er1); end
      n_tests++; if (borrow !== eb1) begin n_fail++; $display("FAIL b2b_first_borrow: got %b expected %b", borrow, eb1); end
      op = 2'b11; in_a = a2; in_b = b2; start = 1'b1;
      tick();
      start = 1'b0; lat = 1;
      n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept: got %b expected 1", busy); end
      while (!done && lat < 60) begin tick(); lat++; end
      n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 6", lat); end
      n_tests++; if (result !== er2) begin n_fail++; $display("FAIL b2b_second_result: got %h expected %h", result, er2); end
      n_tests++; if (borrow !== eb2) begin n_fail++; $display("FAIL b2b_second_borrow: got %b expected %b", borrow, eb2); end
      tick();
   endtask

   task automatic test_random();
      int lat, bc; logic [W:0] r, er; logic bw, ebw; logic [1:0] o; logic [W-1:0] a, b;
      for (int i = 0; i < 1000; i++) begin
         o = 2'($urandom_range(0, 3)); a = rnd_opnd(); b = rnd_opnd();
         model(o, a, b, er, ebw);
         run_op(o, a, b, lat, bc, r, bw);
         n_tests++; if (lat !== 6) begin n_fail++; $display("FAIL rand_latency[%0d]: got %0d expected 6", i, lat); end
         n_tests++; if (r !== er) begin n_fail++; $display("FAIL rand_result[%0d] op=%0d: got %h expected %h", i, o, r, er); end
         n_tests++; if (bw !== ebw) begin n_fail++; $display("FAIL rand_borrow[%0d] op=%0d: got %b expected %b", i, o, bw, ebw); end
         n_tests++; if (stab_err !== 1'b0) begin n_fail++; $display("FAIL rand_stable[%0d]: got %b expected 0", i, stab_err); end
      end
      tick();
   endtask

   task automatic test_sweep();
      int chunk_tab [4] = '{1, 7, 172, 515};
      int lat_g [4]; logic seen [4]; logic [W:0] res_g [4]; logic bw_g [4];
      logic [W:0] er; logic ebw; logic [W-1:0] a, b; int cyc; logic all_seen; int exp_lat;
      for (int i = 0; i < 24; i++) begin
         a = rnd_opnd(); b = rnd_opnd();
         model(2'(i % 4), a, b, er, ebw);
         sw_op = 2'(i % 4); sw_a = a; sw_b = b; sw_start = 1'b1;
         tick();
         sw_start = 1'b0; sw_a = ~a; sw_b = ~b;
         for (int g = 0; g < 4; g++) begin seen[g] = 1'b0; lat_g[g] = -1; end
         cyc = 1; all_seen = 1'b0;
         while (cyc <= 600 && !all_seen) begin
            for (int g = 0; g < 4; g++) begin
               if (!seen[g] && sw_done[g]) begin
                  seen[g] = 1'b1; lat_g[g] = cyc; res_g[g] = sw_result[g]; bw_g[g] = sw_borrow[g];
               end
            end
            all_seen = seen[0] && seen[1] && seen[2] && seen[3];
            if (!all_seen) begin tick(); cyc++; end
         end
         for (int g = 0; g < 4; g++) begin
            exp_lat = (W + chunk_tab[g]) / chunk_tab[g] + 1;
            n_tests++; if (lat_g[g] !== exp_lat) begin n_fail++; $display("FAIL sweep_latency[C=%0d,%0d]: got %0d expected %0d", chunk_tab[g], i, lat_g[g], exp_lat); end
            if (seen[g]) begin
               n_tests++; if (res_g[g] !== er) begin n_fail++; $display("FAIL sweep_result[C=%0d,%0d]: got %h expected %h", chunk_tab[g], i, res_g[g], er); end
               n_tests++; if (bw_g[g] !== ebw) begin n_fail++; $display("FAIL sweep_borrow[C=%0d,%0d]: got %b expected %b", chunk_tab[g], i, bw_g[g], ebw); end
            end
         end
         tick();
      end
   endtask

   initial begin
      start = 1'b0; reset = 1'b1;
      test_reset();
      test_add_carry();
      test_sub();
      test_shift();
      test_ignore_start();
      test_back_to_back();
      test_random();
      test_sweep();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
